hdmi_out_timing: RTL and testbench

- Transmit-side video timing generator for the HDMI TX path.
- Produces the vs/hs/de/RGB raster that a receive-side scaler expects to see.
- Pulls pixels from an AXI-stream-like source (scaler output or frame-buffer reader) with tvalid/tready/tuser, where tuser marks start-of-frame.
- Locks the stream to the raster, blanks on underflow, and resynchronises on start-of-frame errors.

---
 rtl/hdmi_pkg.sv | 62 ++++++
 rtl/hdmi_timing_cnt.sv | 82 ++++++++
 rtl/hdmi_out_timing.sv | 164 ++++++++++++++++
 tb/tb_hdmi_out_timing.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_pkg.sv
// Shared definitions for the HDMI transmit timing path: standard raster sets,
// stream-lock states, the RGB888 pixel type and the colour-bar palette.
package hdmi_pkg;

  localparam int HD1080_H_ACT  = 1920;
  localparam int HD1080_H_FP   = 88;
  localparam int HD1080_H_SYNC = 44;
  localparam int HD1080_H_BP   = 148;
  localparam int HD1080_V_ACT  = 1080;
  localparam int HD1080_V_FP   = 4;
  localparam int HD1080_V_SYNC = 5;
  localparam int HD1080_V_BP   = 36;

  localparam int HD720_H_ACT  = 1280;
  localparam int HD720_H_FP   = 110;
  localparam int HD720_H_SYNC = 40;
  localparam int HD720_H_BP   = 220;
  localparam int HD720_V_ACT  = 720;
  localparam int HD720_V_FP   = 5;
  localparam int HD720_V_SYNC = 5;
  localparam int HD720_V_BP   = 20;

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    ALIGN    = 2'd1,
    RUN      = 2'd2
  } hdmi_state_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
  localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
  localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] BAR_RED     = 24'hFF0000;
  localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
  localparam logic [23:0] BAR_BLACK   = 24'h000000;

  function automatic rgb888_t colorbar_rgb(input logic [2:0] idx);
    case (idx)
      3'd0:    return BAR_WHITE;
      3'd1:    return BAR_YELLOW;
      3'd2:    return BAR_CYAN;
      3'd3:    return BAR_GREEN;
      3'd4:    return BAR_MAGENTA;
      3'd5:    return BAR_RED;
      3'd6:    return BAR_BLUE;
      default: return BAR_BLACK;
    endcase
  endfunction

  // First pixel of bar k, i.e. the smallest h with h*8/h_act >= k
  function automatic int bar_threshold(input int h_act, input int k);
    return (k * h_act + 7) / 8;
  endfunction

endpackage

// File: rtl/hdmi_timing_cnt.sv
// Free-running raster counters with sync/active decode, end-of-frame strobe
// and the colour-bar index of the current column.
module hdmi_timing_cnt
  import hdmi_pkg::*;
#(
  parameter int H_ACT  = HD1080_H_ACT,
  parameter int H_FP   = HD1080_H_FP,
  parameter int H_SYNC = HD1080_H_SYNC,
  parameter int H_BP   = HD1080_H_BP,
  parameter int V_ACT  = HD1080_V_ACT,
  parameter int V_FP   = HD1080_V_FP,
  parameter int V_SYNC = HD1080_V_SYNC,
  parameter int V_BP   = HD1080_V_BP,
  parameter int HW     = $clog2(H_ACT + H_FP + H_SYNC + H_BP),
  parameter int VW     = $clog2(V_ACT + V_FP + V_SYNC + V_BP)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  output logic [HW-1:0] o_h_cnt,
  output logic [VW-1:0] o_v_cnt,
  output logic          o_de,
  output logic          o_hs,
  output logic          o_vs,
  output logic          o_frame_end,
  output logic [2:0]    o_bar_idx
);

  localparam int H_TOTAL = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACT + V_FP + V_SYNC + V_BP;

  localparam logic [HW-1:0] C_H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] C_H_ACT    = HW'(H_ACT);
  localparam logic [HW-1:0] C_HS_START = HW'(H_ACT + H_FP);
  localparam logic [HW-1:0] C_HS_END   = HW'(H_ACT + H_FP + H_SYNC);
  localparam logic [VW-1:0] C_V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] C_V_ACT    = VW'(V_ACT);
  localparam logic [VW-1:0] C_VS_START = VW'(V_ACT + V_FP);
  localparam logic [VW-1:0] C_VS_END   = VW'(V_ACT + V_FP + V_SYNC);

  logic [HW-1:0] r_h_cnt;
  logic [VW-1:0] r_v_cnt;
  logic          w_h_last;
  logic          w_v_last;
  logic [7:1]    w_above;
  logic [2:0]    w_bar_idx;

  assign w_h_last = (r_h_cnt == C_H_LAST);
  assign w_v_last = (r_v_cnt == C_V_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_h_last) begin
      r_h_cnt <= '0;
      r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
    end else begin
      r_h_cnt <= r_h_cnt + 1'b1;
    end
  end

  // Bar boundaries are elaboration-time constants; only comparators remain
  for (genvar k = 1; k < 8; k++) begin : g_bar_cmp
    assign w_above[k] = (r_h_cnt >= HW'(bar_threshold(H_ACT, k)));
  end

  always_comb begin
    w_bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (w_above[k]) w_bar_idx = 3'(k);
    end
  end

  assign o_h_cnt     = r_h_cnt;
  assign o_v_cnt     = r_v_cnt;
  assign o_de        = (r_h_cnt < C_H_ACT) && (r_v_cnt < C_V_ACT);
  assign o_hs        = (r_h_cnt >= C_HS_START) && (r_h_cnt < C_HS_END);
  assign o_vs        = (r_v_cnt >= C_VS_START) && (r_v_cnt < C_VS_END);
  assign o_frame_end = w_h_last && w_v_last;
  assign o_bar_idx   = w_bar_idx;

endmodule

// File: rtl/hdmi_out_timing.sv
// HDMI TX raster generator that locks a tuser-framed pixel stream to the
// raster; define HDMI_OUT_COLORBAR_EN to fill unfed active slots with colour bars.
module hdmi_out_timing
  import hdmi_pkg::*;
#(
  parameter int   H_ACT    = HD1080_H_ACT,
  parameter int   H_FP     = HD1080_H_FP,
  parameter int   H_SYNC   = HD1080_H_SYNC,
  parameter int   H_BP     = HD1080_H_BP,
  parameter int   V_ACT    = HD1080_V_ACT,
  parameter int   V_FP     = HD1080_V_FP,
  parameter int   V_SYNC   = HD1080_V_SYNC,
  parameter int   V_BP     = HD1080_V_BP,
  parameter logic SYNC_POL = 1'b1
) (
  input  logic        pixclk_in,
  input  logic        rst_n,
  input  logic        tvalid_i,
  input  logic [23:0] tdata_i,
  input  logic        tuser_i,
  output logic        tready_o,
  input  logic        underflow_clr_i,
  output logic        vs_out,
  output logic        hs_out,
  output logic        de_out,
  output logic [23:0] data_out,
  output logic        frame_start_o,
  output logic        locked_o,
  output logic        underflow_o,
  output logic        sof_err_o
);

  localparam int HW = $clog2(H_ACT + H_FP + H_SYNC + H_BP);
  localparam int VW = $clog2(V_ACT + V_FP + V_SYNC + V_BP);

  localparam logic [1:0] S_WAIT_SOF = WAIT_SOF;
  localparam logic [1:0] S_ALIGN    = ALIGN;
  localparam logic [1:0] S_RUN      = RUN;

`ifdef HDMI_OUT_COLORBAR_EN
  localparam bit COLORBAR = 1'b1;
`else
  localparam bit COLORBAR = 1'b0;
`endif

  logic [HW-1:0] w_h_cnt;
  logic [VW-1:0] w_v_cnt;
  logic          w_de_c;
  logic          w_hs_c;
  logic          w_vs_c;
  logic          w_frame_end;
  logic [2:0]    w_bar_idx;

  logic [1:0]    r_state;
  logic [1:0]    w_next_state;
  logic          w_sof_slot;
  logic          w_tready;
  logic          w_take;
  logic          w_sof_err;
  logic          w_underflow;
  rgb888_t       w_fill;
  rgb888_t       w_pix;

  logic          r_de;
  logic          r_hs;
  logic          r_vs;
  rgb888_t       r_data;
  logic          r_frame_start;
  logic          r_underflow;
  logic          r_sof_err;

  hdmi_timing_cnt #(
    .H_ACT  (H_ACT),
    .H_FP   (H_FP),
    .H_SYNC (H_SYNC),
    .H_BP   (H_BP),
    .V_ACT  (V_ACT),
    .V_FP   (V_FP),
    .V_SYNC (V_SYNC),
    .V_BP   (V_BP),
    .HW     (HW),
    .VW     (VW)
  ) u_cnt (
    .i_clk       (pixclk_in),
    .i_rst_n     (rst_n),
    .o_h_cnt     (w_h_cnt),
    .o_v_cnt     (w_v_cnt),
    .o_de        (w_de_c),
    .o_hs        (w_hs_c),
    .o_vs        (w_vs_c),
    .o_frame_end (w_frame_end),
    .o_bar_idx   (w_bar_idx)
  );

  assign w_sof_slot = (w_h_cnt == '0) && (w_v_cnt == '0);

  // In RUN a pixel is accepted only when its tuser agrees with the raster origin
  always_comb begin
    w_next_state = r_state;
    w_tready     = 1'b0;
    w_sof_err    = 1'b0;
    w_underflow  = 1'b0;
    case (r_state)
      S_WAIT_SOF: begin
        w_tready = tvalid_i & ~tuser_i;
        if (tvalid_i && tuser_i) w_next_state = S_ALIGN;
      end
      S_ALIGN: begin
        if (w_frame_end) w_next_state = S_RUN;
      end
      S_RUN: begin
        if (w_de_c) begin
          if (!tvalid_i) begin
            w_underflow = 1'b1;
          end else if (tuser_i == w_sof_slot) begin
            w_tready = 1'b1;
          end else begin
            w_sof_err    = 1'b1;
            w_next_state = S_WAIT_SOF;
          end
        end
      end
      default: w_next_state = S_WAIT_SOF;
    endcase
  end

  assign w_take = w_tready && (r_state == S_RUN);
  assign w_fill = COLORBAR ? colorbar_rgb(w_bar_idx) : rgb888_t'(24'h0);
  assign w_pix  = !w_de_c ? rgb888_t'(24'h0) : (w_take ? rgb888_t'(tdata_i) : w_fill);

  always_ff @(posedge pixclk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_WAIT_SOF;
      r_de          <= 1'b0;
      r_hs          <= ~SYNC_POL;
      r_vs          <= ~SYNC_POL;
      r_data        <= '0;
      r_frame_start <= 1'b0;
      r_underflow   <= 1'b0;
      r_sof_err     <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_de          <= w_de_c;
      r_hs          <= w_hs_c ? SYNC_POL : ~SYNC_POL;
      r_vs          <= w_vs_c ? SYNC_POL : ~SYNC_POL;
      r_data        <= w_pix;
      r_frame_start <= w_take && w_sof_slot;
      r_underflow   <= w_underflow | (r_underflow & ~underflow_clr_i);
      r_sof_err     <= w_sof_err;
    end
  end

  // Held low during reset so nothing is consumed while the raster is frozen
  assign tready_o      = w_tready & rst_n;
  assign de_out        = r_de;
  assign hs_out        = r_hs;
  assign vs_out        = r_vs;
  assign data_out      = r_data;
  assign frame_start_o = r_frame_start;
  assign locked_o      = (r_state == S_RUN);
  assign underflow_o   = r_underflow;
  assign sof_err_o     = r_sof_err;

endmodule

// File: tb/tb_hdmi_out_timing.sv
// Self-checking bench for hdmi_out_timing on a 14x7 raster with a randomized
// tuser-framed pixel source and a raster-position reference model.
module tb_hdmi_out_timing;

  localparam int   HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int   VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int   HT = HA + HF + HS + HB;
  localparam int   VT = VA + VF + VS + VB;
  localparam int   FR = HT * VT;
  localparam logic POL = 1'b1;

`ifdef HDMI_OUT_COLORBAR_EN
  localparam bit COLORBAR = 1'b1;
`else
  localparam bit COLORBAR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tvalid_i;
  logic [23:0] tdata_i;
  logic        tuser_i;
  logic        tready_o;
  logic        underflow_clr_i;
  logic        vs_out;
  logic        hs_out;
  logic        de_out;
  logic [23:0] data_out;
  logic        frame_start_o;
  logic        locked_o;
  logic        underflow_o;
  logic        sof_err_o;

  always #5 clk = ~clk;

  hdmi_out_timing #(
    .H_ACT(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACT(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(POL)
  ) dut (
    .pixclk_in       (clk),
    .rst_n           (rst_n),
    .tvalid_i        (tvalid_i),
    .tdata_i         (tdata_i),
    .tuser_i         (tuser_i),
    .tready_o        (tready_o),
    .underflow_clr_i (underflow_clr_i),
    .vs_out          (vs_out),
    .hs_out          (hs_out),
    .de_out          (de_out),
    .data_out        (data_out),
    .frame_start_o   (frame_start_o),
    .locked_o        (locked_o),
    .underflow_o     (underflow_o),
    .sof_err_o       (sof_err_o)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: raster position is derived from cycles since reset
  int          cyc;
  int          mode;
  logic        e_de, e_hs, e_vs, e_fs, e_lock, e_uf, e_err;
  logic [23:0] e_data;
  logic        e_tready, obs_tready;
  logic [23:0] bars [8];

  bit src_on;
  int src_idx;
  int drop_idx;
  int err_idx;
  bit clr_req;

  task automatic model_reset();
    cyc    = 0;
    mode   = 0;
    e_de   = 1'b0;
    e_hs   = ~POL;
    e_vs   = ~POL;
    e_fs   = 1'b0;
    e_lock = 1'b0;
    e_uf   = 1'b0;
    e_err  = 1'b0;
    e_data = 24'h0;
  endtask

  task automatic step();
    int pos, h, v, next_mode;
    bit de, hs, vs, sof, fend, drop, take, err, uf;
    logic [23:0] fill;
    pos  = cyc % FR;
    h    = pos % HT;
    v    = pos / HT;
    de   = (h < HA) && (v < VA);
    hs   = (h >= HA + HF) && (h < HA + HF + HS);
    vs   = (v >= VA + VF) && (v < VA + VF + VS);
    sof  = (pos == 0);
    fend = (pos == FR - 1);
    drop = src_on && (mode == 2) && de && (src_idx == drop_idx);
    if (src_on) begin
      tvalid_i = (mode == 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (drop) tvalid_i = 1'b0;
      tdata_i = 24'(src_idx);
      tuser_i = (src_idx == 0) || (de && src_idx == err_idx);
    end else begin
      tvalid_i = 1'b0;
      tdata_i  = 24'($urandom);
      tuser_i  = 1'($urandom_range(0, 1));
    end
    underflow_clr_i = clr_req;
    e_tready  = 1'b0;
    next_mode = mode;
    err       = 1'b0;
    uf        = 1'b0;
    if (mode == 0) begin
      e_tready = tvalid_i && !tuser_i;
      if (tvalid_i && tuser_i) next_mode = 1;
    end else if (mode == 1) begin
      if (fend) next_mode = 2;
    end else if (de) begin
      if (!tvalid_i) uf = 1'b1;
      else if (tuser_i == sof) e_tready = 1'b1;
      else begin err = 1'b1; next_mode = 0; end
    end
    take = e_tready && (mode == 2);
    fill = (de && COLORBAR) ? bars[(h * 8) / HA] : 24'h0;
    #1;
    obs_tready = tready_o;
    @(posedge clk);
    e_de   = de;
    e_hs   = hs ? POL : ~POL;
    e_vs   = vs ? POL : ~POL;
    e_data = de ? (take ? tdata_i : fill) : 24'h0;
    e_fs   = take && sof;
    e_err  = err;
    e_uf   = uf ? 1'b1 : (clr_req ? 1'b0 : e_uf);
    mode   = next_mode;
    e_lock = (mode == 2);
    if (src_on) begin
      if (tvalid_i && e_tready) src_idx = (src_idx + 1) % 32;
      else if (drop) begin src_idx = (src_idx + 1) % 32; drop_idx = -1; end
      if (err) err_idx = -1;
    end
    clr_req = 1'b0;
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if ({de_out, hs_out, vs_out, frame_start_o, locked_o, underflow_o, sof_err_o, data_out} !==
        {1'b0, ~POL, ~POL, 4'b0, 24'h0}) begin
      failures++;
      $display("[TB] FAIL reset_outputs got=%h exp=%h",
               {de_out, hs_out, vs_out, frame_start_o, locked_o, underflow_o, sof_err_o, data_out},
               {1'b0, ~POL, ~POL, 4'b0, 24'h0});
    end
    checks++;
    if (tready_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_tready got=%b exp=0", tready_o);
    end
  endtask

  task automatic test_timing();
    int n_hs = 0, n_vs = 0, n_de = 0, line0 = 0;
    src_on = 1'b0;
    for (int i = 0; i < 2 * FR; i++) begin
      step();
      checks++;
      if ({de_out, hs_out, vs_out, frame_start_o, locked_o, underflow_o, sof_err_o, data_out, tready_o} !==
          {e_de, e_hs, e_vs, e_fs, e_lock, e_uf, e_err, e_data, e_tready}) begin
        failures++;
        $display("[TB] FAIL timing cyc=%0d got=%h exp=%h", cyc,
                 {de_out, hs_out, vs_out, frame_start_o, locked_o, underflow_o, sof_err_o, data_out, tready_o},
                 {e_de, e_hs, e_vs, e_fs, e_lock, e_uf, e_err, e_data, e_tready});
      end
      if (de_out === 1'b1 && line0 < 8) begin
        checks++;
        if (data_out !== (COLORBAR ? bars[line0] : 24'h0)) begin
          failures++;
          $display("[TB] FAIL line0_fill px=%0d got=%h exp=%h", line0, data_out,
                   COLORBAR ? bars[line0] : 24'h0);
        end
        line0++;
      end
      if (i >= FR) begin
        n_hs += (hs_out === POL) ? 1 : 0;
        n_vs += (vs_out === POL) ? 1 : 0;
        n_de += (de_out === 1'b1) ? 1 : 0;
      end
    end
    checks++;
    if (n_hs != 2 * VT || n_vs != HT || n_de != HA * VA) begin
      failures++;
      $display("[TB] FAIL timing_counts got hs=%0d vs=%0d de=%0d exp hs=%0d vs=%0d de=%0d",
               n_hs, n_vs, n_de, 2 * VT, HT, HA * VA);
    end
  endtask

  task automatic test_lock();
    int got = 0;
    src_on  = 1'b1;
    src_idx = $urandom_range(1, 31);
    for (int i = 0; i < 6 * FR && got < 32; i++) begin
      step();
      checks++;
      if ({de_out, hs_out, vs_out, frame_start_o, locked_o, underflow_o, sof_err_o, data_out, obs_tready} !==
          {e_de, e_hs, e_vs, e_fs, e_lock, e_uf, e_err, e_data, e_tready}) begin
        failures++;
        $display("[TB] FAIL lock cyc=%0d got=%h exp=%h", cyc,
                 {de_out, hs_out, vs_out, frame_start_o, locked_o, underflow_o, sof_err_o, data_out, obs_tready},
                 {e_de, e_hs, e_vs, e_fs, e_lock, e_uf, e_err, e_data, e_tready});
      end
      if (locked_o === 1'b1 && de_out === 1'b1) begin
        checks++;
        if (data_out !== 24'(got) || frame_start_o !== (got == 0)) begin
          failures++;
          $display("[TB] FAIL lock_frame px=%0d got=%h/%b exp=%h/%b", got, data_out,
                   frame_start_o, 24'(got), got == 0);
        end
        got++;
      end
    end
    checks++;
    if (got != 32 || locked_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL lock_done got px=%0d locked=%b exp px=32 locked=1", got, locked_o);
    end
  endtask

  task automatic test_underflow();
    drop_idx = 10;
    for (int i = 0; i < 2 * FR; i++) begin
      step();
      checks++;
      if ({de_out, frame_start_o, locked_o, underflow_o, sof_err_o, data_out, obs_tready} !==
          {e_de, e_fs, e_lock, e_uf, e_err, e_data, e_tready}) begin
        failures++;
        $display("[TB] FAIL underflow cyc=%0d got=%h exp=%h", cyc,
                 {de_out, frame_start_o, locked_o, underflow_o, sof_err_o, data_out, obs_tready},
                 {e_de, e_fs, e_lock, e_uf, e_err, e_data, e_tready});
      end
    end
    checks++;
    if (underflow_o !== 1'b1 || locked_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL underflow_flag got uf=%b lock=%b exp uf=1 lock=1", underflow_o, locked_o);
    end
    clr_req = 1'b1;
    step();
    checks++;
    if (underflow_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL underflow_clear got=%b exp=0", underflow_o);
    end
  endtask

  task automatic test_sof_error();
    int n_err = 0;
    err_idx = 21;
    for (int i = 0; i < 3 * FR; i++) begin
      step();
      n_err += (sof_err_o === 1'b1) ? 1 : 0;
      checks++;
      if ({de_out, frame_start_o, locked_o, underflow_o, sof_err_o, data_out, obs_tready} !==
          {e_de, e_fs, e_lock, e_uf, e_err, e_data, e_tready}) begin
        failures++;
        $display("[TB] FAIL sof_err cyc=%0d got=%h exp=%h", cyc,
                 {de_out, frame_start_o, locked_o, underflow_o, sof_err_o, data_out, obs_tready},
                 {e_de, e_fs, e_lock, e_uf, e_err, e_data, e_tready});
      end
    end
    checks++;
    if (n_err != 1 || locked_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL sof_err_relock got pulses=%0d lock=%b exp pulses=1 lock=1", n_err, locked_o);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2 * FR && (cyc % FR) != HT + 5; i++) step();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({de_out, hs_out, vs_out, frame_start_o, locked_o, underflow_o, sof_err_o, data_out, tready_o} !==
        {1'b0, ~POL, ~POL, 4'b0, 24'h0, 1'b0}) begin
      failures++;
      $display("[TB] FAIL reset_mid_async got=%h exp=%h",
               {de_out, hs_out, vs_out, frame_start_o, locked_o, underflow_o, sof_err_o, data_out, tready_o},
               {1'b0, ~POL, ~POL, 4'b0, 24'h0, 1'b0});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3 * FR; i++) begin
      step();
      checks++;
      if ({de_out, hs_out, vs_out, frame_start_o, locked_o, underflow_o, sof_err_o, data_out, obs_tready} !==
          {e_de, e_hs, e_vs, e_fs, e_lock, e_uf, e_err, e_data, e_tready}) begin
        failures++;
        $display("[TB] FAIL reset_mid cyc=%0d got=%h exp=%h", cyc,
                 {de_out, hs_out, vs_out, frame_start_o, locked_o, underflow_o, sof_err_o, data_out, obs_tready},
                 {e_de, e_hs, e_vs, e_fs, e_lock, e_uf, e_err, e_data, e_tready});
      end
    end
    checks++;
    if (locked_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_mid_relock got=%b exp=1", locked_o);
    end
  endtask

  initial begin
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    rst_n           = 1'b0;
    tvalid_i        = 1'b1;
    tuser_i         = 1'b0;
    tdata_i         = 24'h123456;
    underflow_clr_i = 1'b0;
    src_on          = 1'b0;
    src_idx         = 0;
    drop_idx        = -1;
    err_idx         = -1;
    clr_req         = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    test_timing();
    test_lock();
    test_underflow();
    test_sof_error();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
